// File: rtl/io_bank_pwr_seq_if.sv
// Control/status bundle between the IO ring power manager and io_bank_pwr_seq.
// The sequencer attaches to the slave modport and the power manager to the master modport.
interface io_bank_pwr_seq_if #(
    parameter int NUM_BANKS = 4
);
    logic                 pwr_req_i;
    logic                 ret_req_i;
    logic                 vddio_good_i;
    logic [NUM_BANKS-1:0] bank_en_o;
    logic                 pad_ret_o;
    logic                 ready_o;
    logic                 fault_o;

    modport master (
        output pwr_req_i, ret_req_i, vddio_good_i,
        input  bank_en_o, pad_ret_o, ready_o, fault_o
    );

    modport slave (
        input  pwr_req_i, ret_req_i, vddio_good_i,
        output bank_en_o, pad_ret_o, ready_o, fault_o
    );
endinterface

// File: rtl/io_bank_pwr_seq.sv
// IO pad bank power sequencer: waits for a stable VDDIO, then enables banks in a staggered order.
// Define IO_SEQ_FAULT_LATCH_EN to latch supply loss in a sticky FAULT state instead of auto-retrying.
module io_bank_pwr_seq #(
    parameter int NUM_BANKS      = 4,
    parameter int STABLE_CYCLES  = 16,
    parameter int STAGGER_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rst,
    io_bank_pwr_seq_if.slave   bus
);
    localparam int STAG_TOTAL = NUM_BANKS * STAGGER_CYCLES;
    localparam int MAX_CNT    = (STABLE_CYCLES > STAG_TOTAL) ? STABLE_CYCLES : STAG_TOTAL;
    localparam int CNT_W      = $clog2(MAX_CNT + 1);

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_STABLE  = 3'd1,
        S_STAGGER = 3'd2,
        S_ON      = 3'd3,
        S_RETAIN  = 3'd4
`ifdef IO_SEQ_FAULT_LATCH_EN
        ,
        S_FAULT   = 3'd5
`endif
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     r_due;
    logic [NUM_BANKS-1:0] r_bank_en;
    logic                 r_pad_ret;
    logic                 r_ready;
`ifdef IO_SEQ_FAULT_LATCH_EN
    logic                 r_fault;
`endif

    logic [CNT_W-1:0]     w_cnt_inc;
    logic                 w_go_off;
    logic                 w_supply_lost;

    // Next counter value and the two high-priority exit conditions.
    always_comb begin
        w_cnt_inc     = r_cnt + CNT_W'(1);
        w_go_off      = 1'b0;
        w_supply_lost = 1'b0;
`ifdef IO_SEQ_FAULT_LATCH_EN
        if (r_state != S_FAULT) begin
            w_go_off = ~bus.pwr_req_i;
        end else begin
            w_go_off = 1'b0;
        end
`else
        w_go_off = ~bus.pwr_req_i;
`endif
        if ((r_state == S_STAGGER) || (r_state == S_ON) || (r_state == S_RETAIN)) begin
            w_supply_lost = ~bus.vddio_good_i;
        end else begin
            w_supply_lost = 1'b0;
        end
    end

    // Sequencer FSM with registered outputs; request drop beats supply loss beats retention.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_OFF;
            r_cnt     <= '0;
            r_due     <= '0;
            r_bank_en <= '0;
            r_pad_ret <= 1'b0;
            r_ready   <= 1'b0;
`ifdef IO_SEQ_FAULT_LATCH_EN
            r_fault   <= 1'b0;
`endif
        end else if (w_go_off) begin
            r_state   <= S_OFF;
            r_cnt     <= '0;
            r_bank_en <= '0;
            r_pad_ret <= 1'b0;
            r_ready   <= 1'b0;
        end else if (w_supply_lost) begin
`ifdef IO_SEQ_FAULT_LATCH_EN
            r_state   <= S_FAULT;
            r_fault   <= 1'b1;
`else
            r_state   <= S_STABLE;
`endif
            r_cnt     <= '0;
            r_bank_en <= '0;
            r_pad_ret <= 1'b0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                S_OFF: begin
                    r_cnt <= '0;
                    if (bus.pwr_req_i) begin
                        r_state <= S_STABLE;
                    end else begin
                        r_state <= S_OFF;
                    end
                end
                S_STABLE: begin
                    if (!bus.vddio_good_i) begin
                        r_cnt <= '0;
                    end else if (w_cnt_inc == CNT_W'(STABLE_CYCLES)) begin
                        r_state   <= S_STAGGER;
                        r_cnt     <= '0;
                        r_due     <= CNT_W'(STAGGER_CYCLES);
                        r_bank_en <= NUM_BANKS'(1);
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_STAGGER: begin
                    if (w_cnt_inc == CNT_W'(STAG_TOTAL)) begin
                        r_state   <= S_ON;
                        r_cnt     <= '0;
                        r_bank_en <= '1;
                        r_ready   <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        // Shifting in a one keeps enables contiguous from bank 0 upward.
                        if (w_cnt_inc == r_due) begin
                            r_bank_en <= r_bank_en | (r_bank_en << 1);
                            r_due     <= r_due + CNT_W'(STAGGER_CYCLES);
                        end else begin
                            r_bank_en <= r_bank_en;
                        end
                    end
                end
                S_ON: begin
                    if (bus.ret_req_i) begin
                        r_state   <= S_RETAIN;
                        r_pad_ret <= 1'b1;
                        r_ready   <= 1'b0;
                    end else begin
                        r_state <= S_ON;
                    end
                end
                S_RETAIN: begin
                    if (!bus.ret_req_i) begin
                        r_state   <= S_ON;
                        r_pad_ret <= 1'b0;
                        r_ready   <= 1'b1;
                    end else begin
                        r_state <= S_RETAIN;
                    end
                end
`ifdef IO_SEQ_FAULT_LATCH_EN
                S_FAULT: begin
                    if (!bus.pwr_req_i) begin
                        r_state <= S_OFF;
                        r_fault <= 1'b0;
                    end else begin
                        r_state <= S_FAULT;
                    end
                end
`endif
                default: begin
                    r_state   <= S_OFF;
                    r_cnt     <= '0;
                    r_bank_en <= '0;
                    r_pad_ret <= 1'b0;
                    r_ready   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.bank_en_o = r_bank_en;
    assign bus.pad_ret_o = r_pad_ret;
    assign bus.ready_o   = r_ready;
`ifdef IO_SEQ_FAULT_LATCH_EN
    assign bus.fault_o   = r_fault;
`else
    assign bus.fault_o   = 1'b0;
`endif

endmodule
